product_accumulator: RTL and testbench

Sequential accumulation stage directly downstream of the WTM32 signed tree multiplier. It consumes a stream of 64-bit signed products over a valid/ready handshake and sums a programmed number of them into a signed accumulator. It then presents the total, with a sticky overflow flag, on a result handshake. Together with the multiplier it forms the multiply-accumulate (dot-product) path of the ALU.

---
 rtl/alu_pkg.sv | 17 +
 rtl/sat_add.sv | 29 ++
 rtl/product_accumulator.sv | 86 ++++++++
 tb/tb_product_accumulator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the multiply-accumulate path
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int PROD_W    = 64;
  localparam int ACC_W_DEF = 64;
  localparam int CNT_W_DEF = 8;

  localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - combinational signed adder with overflow detect
// Clamps to the signed range on overflow when SATURATE_EN is defined, wraps otherwise.
module sat_add
  import alu_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] raw;

  assign raw = a + b;
  // Overflow only possible when both addends share a sign the result lacks
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef SATURATE_EN
  assign sum = ovf ? (a[W-1] ? MIN_V : MAX_V) : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums a programmed number of signed products per job
// Optional clamping on overflow via SATURATE_EN (see sat_add).
module product_accumulator
  import alu_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc,
  output logic              overflow,
  output logic              busy
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum;
  logic               sum_ovf;
  logic               accept;
  logic               xfer;

  assign prod_ext = ACC_W'(signed'(prod));
  assign accept   = (state == IDLE) && start;
  assign xfer     = prod_valid && prod_ready;

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   (prod_ext),
    .sum (sum),
    .ovf (sum_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    prod_ready = 1'b0;
    acc_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        prod_ready = 1'b1;
        if (prod_valid && count == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        acc_valid = 1'b1;
        if (acc_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // acc and overflow survive the result handshake; only a new job clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      overflow <= 1'b0;
      count    <= '0;
    end else if (accept) begin
      acc      <= '0;
      overflow <= 1'b0;
      count    <= len;
    end else if (xfer) begin
      acc      <= sum;
      overflow <= overflow | sum_ovf;
      count    <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed self-checking bench for product_accumulator
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        prod_valid = 1'b0;
  logic [63:0] prod = '0;
  logic        prod_ready;
  logic        acc_valid;
  logic        acc_ready = 1'b0;
  logic [63:0] acc;
  logic        overflow;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int prod_hs = 0;
  int res_hs = 0;

  product_accumulator #(.ACC_W(64), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc        (acc),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && prod_valid && prod_ready) prod_hs++;
    if (!rst && acc_valid && acc_ready) res_hs++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag,
               $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [63:0] v, input int gap);
    int n;
    n = 0;
    prod_valid = 1'b1;
    prod       = v;
    while (!prod_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("prod_ready_timeout", 64'(prod_ready), 64'd1);
    tick();
    prod_valid = 1'b0;
    repeat (gap) tick();
  endtask

  int p0, r0;
  logic stable;
  logic [63:0] ovf_exp;

  initial begin
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_acc_valid", 64'(acc_valid), 64'd0);
    check("rst_prod_ready", 64'(prod_ready), 64'd0);
    check("rst_acc", acc, 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    tick();

    // reset in the middle of a job
    start_job(8'd3);
    check("midrst_accum", 64'(prod_ready), 64'd1);
    send(-64'sd50, 0);
    check("midrst_partial", acc, -64'sd50);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_acc", acc, 64'd0);
    check("midrst_ovf", 64'(overflow), 64'd0);
    check("midrst_acc_valid", 64'(acc_valid), 64'd0);
    check("midrst_prod_ready", 64'(prod_ready), 64'd0);
    tick();
    rst = 1'b0;
    r0 = res_hs;
    acc_ready = 1'b1;
    repeat (5) tick();
    check("midrst_no_result", 64'(res_hs - r0), 64'd0);

    // back-to-back products, consumer always ready
    p0 = prod_hs;
    start_job(8'd3);
    prod_valid = 1'b1;
    prod = -64'sd50; tick();
    prod = 64'sd300; tick();
    check("b2b_not_done", 64'(acc_valid), 64'd0);
    prod = 64'sd30; tick();
    prod_valid = 1'b0;
    check("b2b_valid", 64'(acc_valid), 64'd1);
    check("b2b_acc", acc, 64'sd280);
    check("b2b_ovf", 64'(overflow), 64'd0);
    check("b2b_prod_hs", 64'(prod_hs - p0), 64'd3);
    tick();
    check("b2b_idle", 64'(busy), 64'd0);

    // gapped products, held result, start ignored while busy
    acc_ready = 1'b0;
    r0 = res_hs;
    start_job(8'd2);
    send(-64'sd2500, 2);
    send(-64'sd56088, 0);
    check("gap_valid", 64'(acc_valid), 64'd1);
    check("gap_acc", acc, -64'sd58588);
    stable = 1'b1;
    start = 1'b1;
    len = 8'd3;
    repeat (5) begin
      tick();
      if (acc !== -64'sd58588 || acc_valid !== 1'b1) stable = 1'b0;
    end
    check("gap_hold", 64'(stable), 64'd1);
    acc_ready = 1'b1;
    tick();
    start = 1'b0;
    acc_ready = 1'b0;
    check("gap_idle_after_hs", 64'(busy), 64'd0);
    check("gap_acc_kept", acc, -64'sd58588);
    check("gap_res_hs", 64'(res_hs - r0), 64'd1);

    // zero-length job: product offered but never taken
    p0 = prod_hs;
    prod_valid = 1'b1;
    prod = 64'sd100;
    start_job(8'd0);
    check("len0_valid", 64'(acc_valid), 64'd1);
    check("len0_acc", acc, 64'd0);
    check("len0_prod_ready", 64'(prod_ready), 64'd0);
    acc_ready = 1'b1;
    tick();
    tick();
    prod_valid = 1'b0;
    check("len0_idle", 64'(busy), 64'd0);
    check("len0_no_prod_hs", 64'(prod_hs - p0), 64'd0);

    // signed overflow
`ifdef SATURATE_EN
    ovf_exp = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    ovf_exp = 64'h8000_0000_0000_0000;
`endif
    acc_ready = 1'b0;
    start_job(8'd2);
    send(64'h7FFF_FFFF_FFFF_FFFF, 0);
    send(64'd1, 0);
    check("ovf_valid", 64'(acc_valid), 64'd1);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_acc", acc, ovf_exp);
    acc_ready = 1'b1;
    tick();
    check("ovf_sticky_idle", 64'(overflow), 64'd1);

    // two consecutive single-product jobs
    start_job(8'd1);
    check("job1_ovf_cleared", 64'(overflow), 64'd0);
    send(64'sd300, 0);
    check("job1_valid", 64'(acc_valid), 64'd1);
    check("job1_acc", acc, 64'sd300);
    tick();
    start_job(8'd1);
    send(-64'sd25000, 0);
    check("job2_valid", 64'(acc_valid), 64'd1);
    check("job2_acc", acc, -64'sd25000);
    check("job2_ovf", 64'(overflow), 64'd0);
    tick();
    check("job2_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
